// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg: shared FSM state type and default sizes for the configuration-chain loader.
package ccff_loader_pkg;
   typedef enum logic [1:0] {IDLE, FETCH, SHIFT, CHECK} state_e;
   localparam int DEFAULT_BITSTREAM_SIZE = 29696;
   localparam int DEFAULT_WORD_W = 32;
endpackage

// File: rtl/ccff_word_shifter.sv
// ccff_word_shifter: one-word MSB-first shift register with a per-word bit counter.
module ccff_word_shifter
   import ccff_loader_pkg::*;
#(
   parameter int WORD_W = DEFAULT_WORD_W
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              load,
   input  logic              shift,
   input  logic [WORD_W-1:0] data,
   output logic              msb,
   output logic              last_bit
);
   localparam int CW = $clog2(WORD_W + 1);
   logic [WORD_W-1:0] shreg_q, shreg_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   always_comb begin
      shreg_d  = load ? data : shift ? shreg_q << 1 : shreg_q;
      cnt_d    = load ? '0 : shift ? cnt_q + 1'b1 : cnt_q;
      msb      = shreg_q[WORD_W-1];
      last_bit = shift && (cnt_q == CW'(WORD_W - 1));
   end
   always_ff @(posedge prog_clk or negedge pReset) begin
      if (!pReset) begin
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: streams bitstream words serially into a configuration chain
// and verifies the first bit reappears at the chain tail.
module ccff_bitstream_loader
   import ccff_loader_pkg::*;
#(
   parameter int BITSTREAM_SIZE = DEFAULT_BITSTREAM_SIZE,
   parameter int WORD_W         = DEFAULT_WORD_W
) (
   input  logic                                  prog_clk,
   input  logic                                  pReset,
   input  logic                                  start,
   input  logic                                  abort,
   input  logic [WORD_W-1:0]                     word_data,
   input  logic                                  word_valid,
   output logic                                  word_ready,
   output logic                                  ccff_head,
   output logic                                  ccff_shift_en,
   input  logic                                  ccff_tail,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  error,
   output logic [$clog2(BITSTREAM_SIZE+1)-1:0]   bit_count
);
   localparam int CW = $clog2(BITSTREAM_SIZE + 1);
   localparam logic [CW-1:0] SIZE_C = CW'(BITSTREAM_SIZE);
   state_e        state_q, state_d;
   logic [CW-1:0] bit_count_q, bit_count_d, bit_inc;
   logic          first_bit_q, first_bit_d;
   logic          error_q, error_d;
   logic          msb, last_bit;
   ccff_word_shifter #(.WORD_W(WORD_W)) u_shifter (
      .prog_clk (prog_clk),
      .pReset   (pReset),
      .load     (word_ready && word_valid),
      .shift    (ccff_shift_en),
      .data     (word_data),
      .msb      (msb),
      .last_bit (last_bit)
   );
   always_ff @(posedge prog_clk or negedge pReset) begin
      if (!pReset) state_q <= IDLE;
      else         state_q <= state_d;
   end
   assign bit_inc = (bit_count_q == SIZE_C) ? bit_count_q : bit_count_q + 1'b1;
   // Hitting the size ends the load even mid-word; the rest of that word is dropped.
   always_comb begin
      state_d = state_q;
      if (abort) state_d = IDLE;
      else begin
         case (state_q)
            IDLE:    state_d = start ? FETCH : IDLE;
            FETCH:   state_d = word_valid ? SHIFT : FETCH;
            SHIFT:   state_d = (bit_inc == SIZE_C) ? CHECK : last_bit ? FETCH : SHIFT;
            CHECK:   state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end
   always_comb begin
      word_ready    = (state_q == FETCH) && !abort;
      ccff_shift_en = (state_q == SHIFT) && !abort;
      ccff_head     = (state_q == SHIFT) ? msb : 1'b0;
      busy          = state_q != IDLE;
      done          = (state_q == CHECK) && !abort && (ccff_tail == first_bit_q);
   end
   always_comb begin
      bit_count_d = bit_count_q;
      first_bit_d = first_bit_q;
      error_d     = error_q;
      if (state_q == IDLE && start && !abort) begin
         bit_count_d = '0;
         first_bit_d = 1'b0;
         error_d     = 1'b0;
      end
      if (ccff_shift_en) begin
         bit_count_d = bit_inc;
         first_bit_d = (bit_count_q == '0) ? msb : first_bit_q;
      end
      if (state_q == CHECK && !abort && ccff_tail != first_bit_q) error_d = 1'b1;
   end
   always_ff @(posedge prog_clk or negedge pReset) begin
      if (!pReset) begin
         bit_count_q <= '0;
         first_bit_q <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         bit_count_q <= bit_count_d;
         first_bit_q <= first_bit_d;
         error_q     <= error_d;
      end
   end
   assign error     = error_q;
   assign bit_count = bit_count_q;
endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// tb_ccff_bitstream_loader: table, hand-written and random loads against a chain model
// and a bit-queue reference of the expected chain content.
module tb_ccff_bitstream_loader;
   localparam int N  = 64;
   localparam int N2 = 40;
   localparam int W  = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic start = 0, abort = 0, word_valid = 0;
   logic [W-1:0] word_data = '0;
   logic word_ready, head, shen, tail, busy, done, error;
   logic [6:0] bit_count;
   logic [N-1:0] chain = '0;
   int tmode = 0;

   logic start2 = 0, word_valid2 = 0;
   logic [W-1:0] word_data2 = '0;
   logic ready2, head2, shen2, tail2, busy2, done2, error2;
   logic [5:0] bit_count2;
   logic [N2-1:0] chain40 = '0;

   int checks = 0, errors = 0;

   ccff_bitstream_loader #(.BITSTREAM_SIZE(N), .WORD_W(W)) u_dut (
      .prog_clk(clk), .pReset(rst_n), .start(start), .abort(abort),
      .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
      .ccff_head(head), .ccff_shift_en(shen), .ccff_tail(tail),
      .busy(busy), .done(done), .error(error), .bit_count(bit_count)
   );

   ccff_bitstream_loader #(.BITSTREAM_SIZE(N2), .WORD_W(W)) u_dut40 (
      .prog_clk(clk), .pReset(rst_n), .start(start2), .abort(1'b0),
      .word_data(word_data2), .word_valid(word_valid2), .word_ready(ready2),
      .ccff_head(head2), .ccff_shift_en(shen2), .ccff_tail(tail2),
      .busy(busy2), .done(done2), .error(error2), .bit_count(bit_count2)
   );

   always @(posedge clk) if (shen) chain <= {chain[N-2:0], head};
   always @(posedge clk) if (shen2) chain40 <= {chain40[N2-2:0], head2};
   assign tail  = (tmode == 0) ? chain[N-1] : (tmode == 1) ? 1'b0 : 1'b1;
   assign tail2 = chain40[N2-1];

   typedef struct {
      logic [W-1:0] w0, w1;
      int gap, tm;
      bit exp_done, exp_err;
      int exp_busy;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference chain content: the stream as a bit queue, first bit deepest in the chain.
   function automatic logic [63:0] expect_chain(input logic [W-1:0] w0, input logic [W-1:0] w1, input int n);
      bit q[$];
      logic [63:0] r = '0;
      for (int i = W - 1; i >= 0; i--) q.push_back(w0[i]);
      for (int i = W - 1; i >= 0; i--) q.push_back(w1[i]);
      for (int k = 0; k < n; k++) r[n-1-k] = q[k];
      return r;
   endfunction

   task automatic run_load(input logic [W-1:0] w0, input logic [W-1:0] w1, input int gap,
                           output int n_done, output int n_busy, output int n_act,
                           output int n_shift, output bit ovl, output bit to);
      int wi = 0, gl = gap, cyc = 0;
      bit acc;
      logic [W-1:0] ws[2];
      ws[0] = w0;
      ws[1] = w1;
      n_done = 0; n_busy = 0; n_act = 0; n_shift = 0; ovl = 0; to = 1;
      start = 1;
      @(posedge clk); #1 start = 0;
      while (cyc < 400) begin
         word_valid = (wi < 2) && (wi == 0 || gl == 0);
         word_data  = ws[(wi > 1) ? 1 : wi];
         #1;
         if (!busy) begin
            to = 0;
            break;
         end
         n_busy++;
         if (done) n_done++;
         if (shen) n_shift++;
         if (word_ready) n_act++;
         if (word_ready && shen) ovl = 1;
         acc = word_ready && word_valid;
         if (word_ready && !word_valid && wi == 1) gl--;
         @(posedge clk); #1;
         if (acc) wi++;
         cyc++;
      end
      word_valid = 0;
      @(posedge clk); #1;
   endtask

   task automatic verify(input string tag, input logic [W-1:0] w0, input logic [W-1:0] w1, input int gap,
                         input bit e_done, input bit e_err, input int e_busy);
      int nd, nb, na, ns;
      bit ovl, to;
      run_load(w0, w1, gap, nd, nb, na, ns, ovl, to);
      check({tag, " timeout"}, 64'(to), 64'd0);
      check({tag, " ready_with_shift"}, 64'(ovl), 64'd0);
      check({tag, " done_pulses"}, 64'(nd), 64'(e_done));
      check({tag, " error"}, 64'(error), 64'(e_err));
      check({tag, " busy_cycles"}, 64'(nb), 64'(e_busy));
      check({tag, " fetch_shift_cycles"}, 64'(na + ns), 64'(e_busy - 1));
      check({tag, " shift_cycles"}, 64'(ns), 64'(N));
      check({tag, " bit_count"}, 64'(bit_count), 64'(N));
      check({tag, " chain"}, chain, expect_chain(w0, w1, N));
   endtask

   initial begin
      vec_t vecs[5];
      int sc, cyc, wi2, nd2, ns2;
      bit acc2, first, tail_v, pass;
      logic [W-1:0] rw0, rw1;
      int rg;
      vecs[0] = '{32'h8000_0001, 32'hFFFF_0000, 0, 0, 1'b1, 1'b0, 67};
      vecs[1] = '{32'h8000_0001, 32'hFFFF_0000, 5, 0, 1'b1, 1'b0, 72};
      vecs[2] = '{32'h8000_0001, 32'hFFFF_0000, 0, 1, 1'b0, 1'b1, 67};
      vecs[3] = '{32'h1234_5678, 32'hDEAD_BEEF, 2, 2, 1'b0, 1'b1, 69};
      vecs[4] = '{32'h7FFF_FFFF, 32'h0000_0000, 0, 1, 1'b1, 1'b0, 67};

      #12;
      check("reset_outputs", 64'({busy, shen, head, word_ready, done, error, bit_count}), 64'd0);
      @(negedge clk) rst_n = 1;
      @(posedge clk); #1;
      check("idle_after_reset", 64'({busy, word_ready, shen}), 64'd0);

      for (int i = 0; i < 5; i++) begin
         tmode = vecs[i].tm;
         verify($sformatf("vec%0d", i), vecs[i].w0, vecs[i].w1, vecs[i].gap,
                vecs[i].exp_done, vecs[i].exp_err, vecs[i].exp_busy);
      end
      tmode = 0;

      // abort in the tenth SHIFT cycle
      start = 1;
      @(posedge clk); #1 start = 0;
      word_valid = 1;
      word_data = 32'hA5A5_0F0F;
      sc = 0; cyc = 0;
      while (sc < 9 && cyc < 100) begin
         #1;
         if (shen) sc++;
         @(posedge clk); #1;
         cyc++;
      end
      check("abort_reach_shift", 64'(sc), 64'd9);
      abort = 1;
      #1;
      check("abort_shift_en_same_cycle", 64'({shen, done, word_ready}), 64'd0);
      @(posedge clk); #1;
      abort = 0;
      word_valid = 0;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_bit_count", 64'(bit_count), 64'd9);
      check("abort_no_done", 64'(done), 64'd0);

      // start together with abort is ignored
      start = 1; abort = 1;
      @(posedge clk); #1;
      start = 0; abort = 0;
      #1;
      check("start_with_abort", 64'(busy), 64'd0);

      // reset pulled mid-shift, then a clean reload
      start = 1;
      @(posedge clk); #1 start = 0;
      word_valid = 1;
      word_data = 32'hFFFF_FFFF;
      repeat (5) @(posedge clk);
      #1 rst_n = 0;
      #1;
      check("reset_mid_shift", 64'({busy, shen, head, word_ready, done, error, bit_count}), 64'd0);
      word_valid = 0;
      @(negedge clk) rst_n = 1;
      repeat (3) @(posedge clk);
      #1;
      check("wait_for_start_after_reset", 64'(busy), 64'd0);
      verify("reload", 32'hC3C3_3C3C, 32'h0F0F_F0F0, 0, 1'b1, 1'b0, 67);

      // 40-bit chain: second word truncated after 8 bits
      start2 = 1;
      @(posedge clk); #1 start2 = 0;
      wi2 = 0; nd2 = 0; ns2 = 0; cyc = 0;
      word_valid2 = 1;
      while (cyc < 200) begin
         word_data2 = (wi2 == 0) ? 32'h9ABC_DEF0 : 32'h5A00_FFFF;
         #1;
         if (!busy2) break;
         if (done2) nd2++;
         if (shen2) ns2++;
         acc2 = ready2 && word_valid2;
         @(posedge clk); #1;
         if (acc2) wi2++;
         cyc++;
      end
      word_valid2 = 0;
      check("s40_timeout", 64'(cyc < 200), 64'd1);
      check("s40_shifts", 64'(ns2), 64'(N2));
      check("s40_words", 64'(wi2), 64'd2);
      check("s40_done", 64'(nd2), 64'd1);
      check("s40_error", 64'(error2), 64'd0);
      check("s40_bit_count", 64'(bit_count2), 64'(N2));
      check("s40_chain", 64'(chain40), expect_chain(32'h9ABC_DEF0, 32'h5A00_FFFF, N2));

      // randomized loads checked against the reference model
      for (int r = 0; r < 20; r++) begin
         rw0 = $urandom;
         rw1 = $urandom;
         rg = $urandom_range(0, 6);
         tmode = $urandom_range(0, 2);
         first = rw0[W-1];
         tail_v = (tmode == 0) ? first : (tmode == 1) ? 1'b0 : 1'b1;
         pass = (tail_v == first);
         verify($sformatf("rnd%0d", r), rw0, rw1, rg, pass, !pass, N + (N + W - 1) / W + rg + 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
